// File: rtl/ic_tester_pkg.sv
// Shared codes, per-type geometry helpers and FSM state type for the
// logic-gate IC test sequencer.
package ic_tester_pkg;

  localparam logic [2:0] IC_NOT = 3'd0;
  localparam logic [2:0] IC_IN2 = 3'd1;
  localparam logic [2:0] IC_IN3 = 3'd2;
  localparam logic [2:0] IC_IN4 = 3'd3;
  localparam logic [2:0] IC_IN8 = 3'd4;

  localparam logic [1:0] FN_AND  = 2'd0;
  localparam logic [1:0] FN_OR   = 2'd1;
  localparam logic [1:0] FN_NAND = 2'd2;
  localparam logic [1:0] FN_NOR  = 2'd3;

  localparam logic [2:0] SEL_IDLE = 3'b111;

  // The "next vector" step is folded into the last APPLY cycle, so no NEXT state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic type_valid(input logic [2:0] ic_type);
    return ic_type <= IC_IN8;
  endfunction

  function automatic logic [3:0] inputs_per_gate(input logic [2:0] ic_type);
    case (ic_type)
      IC_NOT:  return 4'd1;
      IC_IN2:  return 4'd2;
      IC_IN3:  return 4'd3;
      IC_IN4:  return 4'd4;
      IC_IN8:  return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [2:0] gate_count(input logic [2:0] ic_type);
    case (ic_type)
      IC_NOT:  return 3'd6;
      IC_IN2:  return 3'd4;
      IC_IN3:  return 3'd3;
      IC_IN4:  return 3'd2;
      IC_IN8:  return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [5:0] gate_mask(input logic [2:0] ic_type);
    logic [6:0] m;
    m = (7'd1 << gate_count(ic_type)) - 7'd1;
    return m[5:0];
  endfunction

  // Terminal vector 2^k-1, nine bits so k=8 does not wrap.
  function automatic logic [8:0] last_vec(input logic [2:0] ic_type);
    logic [9:0] m;
    m = (10'd1 << inputs_per_gate(ic_type)) - 10'd1;
    return m[8:0];
  endfunction

  function automatic logic [7:0] operand_mask(input logic [2:0] ic_type);
    case (ic_type)
      IC_NOT:  return 8'h01;
      IC_IN2:  return 8'h03;
      IC_IN3:  return 8'h07;
      IC_IN4:  return 8'h0F;
      IC_IN8:  return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/ic_expected_calc.sv
// Expected gate output for the current vector, replicated onto every
// gate slot that exists for the IC type; unused slots read 0.
module ic_expected_calc
  import ic_tester_pkg::*;
(
  input  logic [2:0] ic_type,
  input  logic [1:0] gate_fn,
  input  logic [7:0] vec,
  output logic [5:0] expected
);

  logic [7:0] in_mask;
  logic [7:0] used;
  logic       reduced;
  logic       bit_exp;

  always_comb begin
    in_mask = operand_mask(ic_type);
    used    = vec & in_mask;
    reduced = 1'b0;
    case (gate_fn)
      FN_AND, FN_NAND: reduced = (used == in_mask);
      default:         reduced = (used != 8'd0);
    endcase
    bit_exp = ((gate_fn == FN_NAND) || (gate_fn == FN_NOR)) ? ~reduced : reduced;
    if (ic_type == IC_NOT) bit_exp = ~vec[0];
    expected = {6{bit_exp}} & gate_mask(ic_type);
  end

endmodule

// File: rtl/ic_test_sequencer.sv
// Walks every input combination of one gate IC, holding each vector for
// SETTLE_CYCLES+1 cycles and accumulating a per-gate fail mask.
module ic_test_sequencer
  import ic_tester_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] ic_type,
  input  logic [1:0] gate_fn,
  input  logic [5:0] dut_out,
  output logic [2:0] select,
  output logic [7:0] vec,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] fail_mask,
  output logic [1:0] state_dbg
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

  state_t     state_q, state_d;
  logic [2:0] type_q, type_d;
  logic [1:0] fn_q, fn_d;
  logic [8:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [5:0] fail_q, fail_d;
  logic       pass_q, pass_d;
  logic [5:0] expected;
  logic [5:0] sample_fail;

  ic_expected_calc u_expected (
    .ic_type  (type_q),
    .gate_fn  (fn_q),
    .vec      (vec_q[7:0]),
    .expected (expected)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      type_q  <= IC_NOT;
      fn_q    <= FN_AND;
      vec_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      fn_q    <= fn_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    fn_d        = fn_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    fail_d      = fail_q;
    pass_d      = pass_q;
    sample_fail = fail_q | ((dut_out ^ expected) & gate_mask(type_q));
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          vec_d  = '0;
          cnt_d  = '0;
          pass_d = 1'b0;
          if (type_valid(ic_type)) begin
            state_d = ST_APPLY;
            type_d  = ic_type;
            fn_d    = gate_fn;
            fail_d  = '0;
          end else begin
            state_d = ST_DONE;
            fail_d  = 6'h3F;
          end
        end
      end
      ST_APPLY: begin
        if (abort) begin
          state_d = ST_IDLE;
          vec_d   = '0;
          cnt_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
        end else if (cnt_q == SETTLE_LAST) begin
          // Final edge of the vector window: sample, then advance or finish.
          fail_d = sample_fail;
          cnt_d  = '0;
          if (vec_q == last_vec(type_q)) begin
            state_d = ST_DONE;
            pass_d  = (sample_fail == 6'd0);
            vec_d   = '0;
          end else begin
            vec_d = vec_q + 9'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q == ST_APPLY);
  assign done      = (state_q == ST_DONE);
  assign select    = busy ? type_q : SEL_IDLE;
  assign vec       = vec_q[7:0];
  assign pass      = pass_q;
  assign fail_mask = fail_q;
  assign state_dbg = state_q;

endmodule
